// File: rtl/setpoint_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : setpoint_encoder_pkg
// Brief  : FSM encodings, default scaling constants and packed-BCD helpers
//          shared by the setpoint encoder and the display path.
// Rev    : 1.0  initial release
// ============================================================================
package setpoint_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_MUL  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam int unsigned c_scale_num_default = 16;
    localparam int unsigned c_code_max_default  = 4095;
    localparam int unsigned c_num_digits        = 4;

    // Digit slice of a packed BCD word; idx 0 is units, idx 3 is thousands.
    function automatic logic [3:0] bcd_digit(input logic [15:0] d, input int unsigned idx);
        return d[idx*4 +: 4];
    endfunction

    function automatic logic has_non_bcd(input logic [15:0] d);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < c_num_digits; i++) begin
            if (bcd_digit(d, i) > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/setpoint_encoder_if.sv
`default_nettype none
// ============================================================================
// Module : setpoint_encoder_if
// Brief  : start/done request bus between the setpoint register and encoder.
// Rev    : 1.0  initial release
// ============================================================================
interface setpoint_encoder_if;
    logic        start;
    logic [15:0] digits;
    logic        busy;
    logic        done;
    logic [11:0] code;
    logic        sat;
    logic        err;

    modport master (
        output start, digits,
        input  busy, done, code, sat, err
    );

    modport slave (
        input  start, digits,
        output busy, done, code, sat, err
    );
endinterface
`default_nettype wire

// File: rtl/setpoint_encoder_bcd_accumulator.sv
`default_nettype none
// ============================================================================
// Module : setpoint_encoder_bcd_accumulator
// Brief  : Captures 4 packed BCD digits and folds them MSD-first into binary
//          with a x10 accumulate, one digit per cycle.
// Rev    : 1.0  initial release
// ============================================================================
module setpoint_encoder_bcd_accumulator
    import setpoint_encoder_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_load,
    input  wire logic [15:0] i_digits,
    output logic      [13:0] o_acc,
    output logic             o_last
);

    logic [15:0] r_sr;
    logic [13:0] r_acc;
    logic [2:0]  r_cnt;
    logic [3:0]  w_msd;
    logic [13:0] w_acc_next;

    assign w_msd      = bcd_digit(r_sr, 3);
    // acc*10 as (acc<<3)+(acc<<1); 9999 is the largest result and fits 14 bits.
    assign w_acc_next = {r_acc[10:0], 3'b000} + {r_acc[12:0], 1'b0} + {10'd0, w_msd};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sr  <= i_digits;
            r_acc <= '0;
            r_cnt <= 3'(c_num_digits);
        end else if (r_cnt != 3'd0) begin
            r_acc <= w_acc_next;
            r_sr  <= {r_sr[11:0], 4'd0};
            r_cnt <= r_cnt - 3'd1;
        end
    end

    assign o_acc  = r_acc;
    assign o_last = (r_cnt == 3'd1);

endmodule
`default_nettype wire

// File: rtl/setpoint_encoder.sv
`default_nettype none
// ============================================================================
// Module : setpoint_encoder
// Brief  : Converts a 4-digit BCD temperature setpoint into a saturated
//          12-bit ADC-count code (BCD->binary, then serial shift-add scale).
// Rev    : 1.0  initial release
// ============================================================================
module setpoint_encoder
    import setpoint_encoder_pkg::*;
#(
    parameter int unsigned SCALE_NUM   = c_scale_num_default,
    parameter int unsigned SCALE_SHIFT = 0,
    parameter int unsigned CODE_MAX    = c_code_max_default
) (
    input  wire logic          clk,
    input  wire logic          rst,
    setpoint_encoder_if.slave  bus
);

    localparam logic [7:0]  c_scale    = 8'(SCALE_NUM);
    localparam logic [21:0] c_code_max = 22'(CODE_MAX);

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_bad;
    logic [13:0] w_acc;
    logic        w_acc_last;
    logic [21:0] w_scaled;

    logic        r_busy;
    logic        r_done;
    logic [11:0] r_code;
    logic        r_sat;
    logic        r_err;
    logic        r_req_bad;
    logic [21:0] r_prod;
    logic [2:0]  r_bit;

    assign w_bad    = has_non_bcd(bus.digits);
    assign w_scaled = r_prod >> SCALE_SHIFT;

    setpoint_encoder_bcd_accumulator u_bcd_acc (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept && !w_bad),
        .i_digits (bus.digits),
        .o_acc    (w_acc),
        .o_last   (w_acc_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // A start coinciding with done is refused; FIN has only just handed back to IDLE.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !r_done) begin
                    w_accept = 1'b1;
                    w_next   = w_bad ? ST_FIN : ST_ACC;
                end
            end
            ST_ACC:  if (w_acc_last) w_next = ST_MUL;
            ST_MUL:  if (r_bit == 3'd7) w_next = ST_FIN;
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_code    <= '0;
            r_sat     <= 1'b0;
            r_err     <= 1'b0;
            r_req_bad <= 1'b0;
            r_prod    <= '0;
            r_bit     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_busy    <= 1'b1;
                        r_req_bad <= w_bad;
                        r_prod    <= '0;
                        r_bit     <= '0;
                    end
                end
                ST_MUL: begin
                    if (c_scale[r_bit]) r_prod <= r_prod + (22'(w_acc) << r_bit);
                    r_bit <= r_bit + 3'd1;
                end
                ST_FIN: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    // A rejected request reports err only; code and sat keep the last good result.
                    if (r_req_bad) begin
                        r_err <= 1'b1;
                    end else begin
                        r_err <= 1'b0;
                        if (w_scaled > c_code_max) begin
                            r_code <= c_code_max[11:0];
                            r_sat  <= 1'b1;
                        end else begin
                            r_code <= w_scaled[11:0];
                            r_sat  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.code = r_code;
    assign bus.sat  = r_sat;
    assign bus.err  = r_err;

endmodule
`default_nettype wire
